mem_io_responder: RTL

//  Responder side of the cpu byte-wide memory bus (mem_a/mem_dout/mem_wr out of cpu, mem_din/io_buffer_full in).

---
 rtl/mem_io_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: synchronous RAM plus memory-mapped UART TX FIFO, UART RX and cycle counter.
// Optional RX path enabled by defining MEM_IO_RESPONDER_RX_EN.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 16,
  parameter int FULL_SLACK     = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_mem_a,
  input  logic [7:0]  cpu_mem_dout,
  input  logic        cpu_mem_wr,
  output logic [7:0]  cpu_mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(TX_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_C   = (PTR_W+1)'(TX_FIFO_DEPTH - FULL_SLACK);
  localparam logic [15:0]    OFF_UART = 16'h0000;
  localparam logic [15:0]    OFF_CNT0 = 16'h0004;
  localparam logic [15:0]    OFF_CNT1 = 16'h0005;
  localparam logic [15:0]    OFF_CNT2 = 16'h0006;
  localparam logic [15:0]    OFF_CNT3 = 16'h0007;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_IO
  } rd_sel_e;

  logic                      is_io;
  logic [15:0]               io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      ram_we;
  logic [7:0]                ram_rd_q;
  logic [7:0]                ram [2**RAM_ADDR_WIDTH];

  rd_sel_e     sel_q, sel_d;
  logic [7:0]  io_rd_q, io_rd_d;
  logic [31:0] counter_q, counter_d;
  logic [31:0] snap_q, snap_d;
  logic        stop_q, stop_d;
  logic        ovf_q, ovf_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       tx_mem [TX_FIFO_DEPTH];

  logic       wr_uart, wr_stop;
  logic       push_req, push_ok, pop, rx_pop;
  logic [7:0] push_byte;
  logic       unused_addr;

  assign is_io   = (cpu_mem_a[17:16] == 2'b11);
  assign io_off  = cpu_mem_a[15:0];
  assign ram_idx = cpu_mem_a[RAM_ADDR_WIDTH-1:0];
  assign ram_we  = cpu_mem_wr && !is_io && !rst_in;
  assign unused_addr = ^cpu_mem_a[31:18];

  assign wr_uart = !rst_in && is_io && cpu_mem_wr && (io_off == OFF_UART);
  assign wr_stop = !rst_in && is_io && cpu_mem_wr && (io_off == OFF_CNT0);

`ifdef MEM_IO_RESPONDER_RX_EN
  assign rx_pop = !rst_in && is_io && !cpu_mem_wr && (io_off == OFF_UART) && rx_valid;
`else
  logic unused_rx;
  assign unused_rx = rx_valid ^ (^rx_data);
  assign rx_pop    = 1'b0;
`endif
  assign rx_ready = rx_pop;

  // The zero filter applies only to UART data writes; the stop marker 0x00 always enters.
  assign push_req  = (wr_uart && (cpu_mem_dout != 8'h00)) || wr_stop;
  assign push_byte = wr_stop ? 8'h00 : cpu_mem_dout;
  assign pop       = (count_q != '0) && tx_ready;
  assign push_ok   = push_req && ((count_q < DEPTH_C) || pop);

  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? tx_mem[rd_ptr_q] : 8'h00;
  assign io_buffer_full = (count_q >= FULL_C);
  assign program_stop   = stop_q;
  assign tx_overflow    = ovf_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_d     = SEL_ZERO;
    io_rd_d   = 8'h00;
    snap_d    = snap_q;
    stop_d    = stop_q || wr_stop;
    ovf_d     = ovf_q || (push_req && !push_ok);
    counter_d = (stop_q || wr_stop) ? counter_q : counter_q + 32'd1;
    wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);

    if (!cpu_mem_wr) begin
      if (!is_io) begin
        sel_d = SEL_RAM;
      end else begin
        sel_d = SEL_IO;
        unique case (io_off)
          OFF_UART: io_rd_d = rx_pop ? rx_data : 8'h00;
          OFF_CNT0: begin
            snap_d  = counter_q;
            io_rd_d = counter_q[7:0];
          end
          OFF_CNT1: io_rd_d = snap_q[15:8];
          OFF_CNT2: io_rd_d = snap_q[23:16];
          OFF_CNT3: io_rd_d = snap_q[31:24];
          default:  io_rd_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_in) begin
      sel_q     <= SEL_ZERO;
      io_rd_q   <= 8'h00;
      counter_q <= 32'd0;
      snap_q    <= 32'd0;
      stop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      sel_q     <= sel_d;
      io_rd_q   <= io_rd_d;
      counter_q <= counter_d;
      snap_q    <= snap_d;
      stop_q    <= stop_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; a reset loop would block RAM inference and contents must survive reset.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= cpu_mem_dout;
    ram_rd_q <= ram[ram_idx];
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) tx_mem[wr_ptr_q] <= push_byte;
  end

  always_comb begin
    unique case (sel_q)
      SEL_RAM: cpu_mem_din = ram_rd_q;
      SEL_IO:  cpu_mem_din = io_rd_q;
      default: cpu_mem_din = 8'h00;
    endcase
  end

endmodule
